// File: rtl/dec_pkg.sv
// dec_pkg: shared state, mode and polarity definitions for the N-to-2^N decoder family
package dec_pkg;

   typedef enum logic [1:0] {ST_IDLE, ST_DIRECT, ST_SCAN} state_t;

   localparam logic MODE_DIRECT = 1'b0;
   localparam logic MODE_SCAN   = 1'b1;
   localparam int   MAX_OUT_W   = 256;

   // all-inactive pattern, wide enough for any supported output; callers truncate
   function automatic logic [MAX_OUT_W-1:0] inactive_pat(input bit active_low);
      return active_low ? '1 : '0;
   endfunction

endpackage

// File: rtl/dec_onehot.sv
// dec_onehot: combinational index to one-hot decode with enable and selectable polarity
module dec_onehot
   import dec_pkg::*;
#(
   parameter int SEL_W      = 2,
   parameter bit ACTIVE_LOW = 1'b1,
   localparam int OUT_W     = 2**SEL_W
) (
   input  logic             en,
   input  logic [SEL_W-1:0] sel,
   output logic [OUT_W-1:0] y
);

   logic [OUT_W-1:0] hot;

   // disabled decode yields the all-inactive pattern rather than a zero one-hot
   always_comb begin
      hot = OUT_W'(1) << sel;
      y   = en ? (ACTIVE_LOW ? ~hot : hot) : OUT_W'(inactive_pat(ACTIVE_LOW));
   end

endmodule

// File: rtl/dec_nx2n_scan.sv
// dec_nx2n_scan: registered N-to-2^N decoder with direct select and dwell-timed scan modes
module dec_nx2n_scan
   import dec_pkg::*;
#(
   parameter int SEL_W      = 2,
   parameter bit ACTIVE_LOW = 1'b1,
   parameter int DWELL_W    = 8,
   localparam int OUT_W     = 2**SEL_W
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               en_n,
   input  logic               mode,
   input  logic [SEL_W-1:0]   sel,
   input  logic [DWELL_W-1:0] dwell,
   output logic [OUT_W-1:0]   y,
   output logic [SEL_W-1:0]   idx,
   output logic               valid,
   output logic               wrap
);

   state_t             state, nxt_state;
   logic [DWELL_W-1:0] cnt, nxt_cnt;
   logic [SEL_W-1:0]   nxt_idx;
   logic               advance, scanning, nxt_wrap;
   logic [OUT_W-1:0]   dec_y;

   // next state and next index/counter; everything is decoded from the next index so y and idx stay aligned
   always_comb begin
      nxt_state = en_n ? ST_IDLE : (mode == MODE_DIRECT ? ST_DIRECT : ST_SCAN);
      scanning  = nxt_state == ST_SCAN && state == ST_SCAN;
      advance   = scanning && cnt >= dwell;
      nxt_idx   = nxt_state == ST_DIRECT ? sel : (scanning ? (advance ? idx + 1'b1 : idx) : '0);
      nxt_cnt   = (scanning && !advance) ? cnt + 1'b1 : '0;
      nxt_wrap  = advance && idx == '1;
   end

   dec_onehot #(.SEL_W(SEL_W), .ACTIVE_LOW(ACTIVE_LOW)) u_dec (
      .en (nxt_state != ST_IDLE),
      .sel(nxt_idx),
      .y  (dec_y)
   );

   // single register stage for state and every output so y never shows a transitional code
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
         cnt   <= '0;
         idx   <= '0;
         y     <= OUT_W'(inactive_pat(ACTIVE_LOW));
         valid <= 1'b0;
         wrap  <= 1'b0;
      end else begin
         state <= nxt_state;
         cnt   <= nxt_cnt;
         idx   <= nxt_idx;
         y     <= dec_y;
         valid <= nxt_state != ST_IDLE;
         wrap  <= nxt_wrap;
      end
   end

endmodule

// File: tb/tb_dec_nx2n_scan.sv
// tb_dec_nx2n_scan: randomized and directed checks of three decoder configurations against a behavioural model
module tb_dec_nx2n_scan;

   logic       clk = 1'b0, rst_n = 1'b1, en_n = 1'b1, mode = 1'b0;
   logic [2:0] sel = '0;
   logic [7:0] dwell = '0;
   logic [3:0] y0, y1;
   logic [7:0] y2;
   logic [1:0] i0, i1;
   logic [2:0] i2;
   logic       v0, v1, v2, w0, w1, w2;

   int cmp = 0, bad = 0;
   int ms[3], midx[3], mcnt[3], mwrap[3];
   int nw[3] = '{4, 4, 8};
   bit al[3] = '{1'b1, 1'b0, 1'b1};

   always #5 clk = ~clk;

   dec_nx2n_scan #(.SEL_W(2), .ACTIVE_LOW(1'b1), .DWELL_W(8)) d0 (
      .clk(clk), .rst_n(rst_n), .en_n(en_n), .mode(mode), .sel(sel[1:0]), .dwell(dwell),
      .y(y0), .idx(i0), .valid(v0), .wrap(w0));
   dec_nx2n_scan #(.SEL_W(2), .ACTIVE_LOW(1'b0), .DWELL_W(8)) d1 (
      .clk(clk), .rst_n(rst_n), .en_n(en_n), .mode(mode), .sel(sel[1:0]), .dwell(dwell),
      .y(y1), .idx(i1), .valid(v1), .wrap(w1));
   dec_nx2n_scan #(.SEL_W(3), .ACTIVE_LOW(1'b1), .DWELL_W(8)) d2 (
      .clk(clk), .rst_n(rst_n), .en_n(en_n), .mode(mode), .sel(sel), .dwell(dwell),
      .y(y2), .idx(i2), .valid(v2), .wrap(w2));

   // packed {y, idx, valid, wrap} of one instance
   function automatic logic [41:0] obs(int k);
      case (k)
         0:       return {32'(y0), 8'(i0), v0, w0};
         1:       return {32'(y1), 8'(i1), v1, w1};
         default: return {32'(y2), 8'(i2), v2, w2};
      endcase
   endfunction

   // model state: 0 idle, 1 direct, 2 scan; idx is the strobed output, mcnt cycles already spent on it
   function automatic logic [41:0] expv(int k);
      logic [31:0] hot, mask;
      mask = (32'd1 << nw[k]) - 32'd1;
      hot  = ms[k] != 0 ? 32'd1 << midx[k] : 32'd0;
      if (al[k]) hot = ~hot & mask;
      return {hot, 8'(midx[k]), ms[k] != 0, mwrap[k] != 0};
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 3; k++) begin
         ms[k] = 0; midx[k] = 0; mcnt[k] = 0; mwrap[k] = 0;
      end
   endtask

   task automatic model_tick();
      for (int k = 0; k < 3; k++) begin
         mwrap[k] = 0;
         if (en_n) begin
            ms[k] = 0; midx[k] = 0; mcnt[k] = 0;
         end else if (!mode) begin
            ms[k] = 1; midx[k] = int'(sel) % nw[k]; mcnt[k] = 0;
         end else if (ms[k] != 2) begin
            ms[k] = 2; midx[k] = 0; mcnt[k] = 0;
         end else if (mcnt[k] >= int'(dwell)) begin
            mwrap[k] = (midx[k] == nw[k] - 1) ? 1 : 0;
            midx[k]  = (midx[k] + 1) % nw[k];
            mcnt[k]  = 0;
         end else begin
            mcnt[k]++;
         end
      end
   endtask

   task automatic step();
      model_tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      #1 rst_n = 1'b0;
      #1;
      model_reset();
      cmp++;
      if ({y0, y1, y2} !== {4'b1111, 4'b0000, 8'hFF}) begin
         bad++; $display("FAIL reset_y got %b %b %b want 1111 0000 11111111", y0, y1, y2);
      end
      cmp++;
      if ({i0, i1, i2, v0, v1, v2, w0, w1, w2} !== '0) begin
         bad++; $display("FAIL reset_ctl got idx %0d %0d %0d valid %b%b%b wrap %b%b%b want zeros", i0, i1, i2, v0, v1, v2, w0, w1, w2);
      end
      rst_n = 1'b1;
      step();
      for (int k = 0; k < 3; k++) begin
         cmp++;
         if (obs(k) !== expv(k)) begin
            bad++; $display("FAIL idle_after_reset dut%0d got %h want %h", k, obs(k), expv(k));
         end
      end
   endtask

   task automatic test_direct();
      logic [3:0] lo_tab[4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
      logic [3:0] hi_tab[4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
      en_n = 1'b0; mode = 1'b0;
      for (int s = 0; s < 4; s++) begin
         sel = 3'(s);
         step();
         cmp++;
         if (y0 !== lo_tab[s] || y1 !== hi_tab[s] || i0 !== 2'(s) || v0 !== 1'b1) begin
            bad++; $display("FAIL direct_sel%0d got y %b/%b idx %0d valid %b want %b/%b idx %0d valid 1", s, y0, y1, i0, v0, lo_tab[s], hi_tab[s], s);
         end
         for (int k = 0; k < 3; k++) begin
            cmp++;
            if (obs(k) !== expv(k)) begin
               bad++; $display("FAIL direct_model dut%0d got %h want %h", k, obs(k), expv(k));
            end
         end
      end
      sel = 3'd5;
      step();
      cmp++;
      if (y2 !== 8'b11011111) begin
         bad++; $display("FAIL direct_sel5_w8 got %b want 11011111", y2);
      end
   endtask

   task automatic test_scan();
      dwell = 8'd2; mode = 1'b1;
      for (int i = 0; i < 26; i++) begin
         step();
         cmp++;
         if (i0 !== 2'((i / 3) % 4) || w0 !== (i == 12 || i == 24)) begin
            bad++; $display("FAIL scan_d2 cycle %0d got idx %0d wrap %b want idx %0d wrap %b", i, i0, w0, (i / 3) % 4, (i == 12 || i == 24));
         end
         for (int k = 0; k < 3; k++) begin
            cmp++;
            if (obs(k) !== expv(k)) begin
               bad++; $display("FAIL scan_model dut%0d cycle %0d got %h want %h", k, i, obs(k), expv(k));
            end
         end
      end
   endtask

   task automatic test_dwell_change();
      mode = 1'b0;
      step();
      mode = 1'b1; dwell = 8'd9;
      repeat (7) step();
      dwell = 8'd3;
      step();
      cmp++;
      if (i0 !== 2'd1) begin
         bad++; $display("FAIL dwell_lower got idx %0d want 1", i0);
      end
      dwell = 8'd0;
      for (int i = 0; i < 16; i++) begin
         step();
         cmp++;
         if (i0 !== 2'((2 + i) % 4) || w0 !== ((2 + i) % 4 == 0)) begin
            bad++; $display("FAIL dwell0 cycle %0d got idx %0d wrap %b want idx %0d wrap %b", i, i0, w0, (2 + i) % 4, ((2 + i) % 4 == 0));
         end
         for (int k = 0; k < 3; k++) begin
            cmp++;
            if (obs(k) !== expv(k)) begin
               bad++; $display("FAIL dwell0_model dut%0d cycle %0d got %h want %h", k, i, obs(k), expv(k));
            end
         end
      end
   endtask

   task automatic test_enable();
      dwell = 8'd1;
      repeat (5) step();
      en_n = 1'b1;
      step();
      cmp++;
      if (y0 !== 4'b1111 || v0 !== 1'b0 || y2 !== 8'hFF) begin
         bad++; $display("FAIL enable_off got y %b %b valid %b want 1111 11111111 valid 0", y0, y2, v0);
      end
      en_n = 1'b0;
      step();
      cmp++;
      if (i0 !== 2'd0 || w0 !== 1'b0 || v0 !== 1'b1 || y0 !== 4'b1110) begin
         bad++; $display("FAIL enable_restart got idx %0d wrap %b valid %b y %b want 0 0 1 1110", i0, w0, v0, y0);
      end
      for (int k = 0; k < 3; k++) begin
         cmp++;
         if (obs(k) !== expv(k)) begin
            bad++; $display("FAIL enable_model dut%0d got %h want %h", k, obs(k), expv(k));
         end
      end
   endtask

   task automatic test_async_reset();
      dwell = 8'd0;
      repeat (6) step();
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      cmp++;
      if ({y0, y1, y2, i0, i1, i2, v0, v1, v2, w0, w1, w2} !== {4'b1111, 4'b0000, 8'hFF, 13'd0}) begin
         bad++; $display("FAIL async_reset got y %b %b %b idx %0d %0d %0d valid %b%b%b", y0, y1, y2, i0, i1, i2, v0, v1, v2);
      end
      #3 rst_n = 1'b1;
      step();
      for (int k = 0; k < 3; k++) begin
         cmp++;
         if (obs(k) !== expv(k)) begin
            bad++; $display("FAIL post_reset_model dut%0d got %h want %h", k, obs(k), expv(k));
         end
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         en_n = $urandom_range(0, 15) == 0;
         if ($urandom_range(0, 7) == 0) mode = ~mode;
         sel = 3'($urandom);
         if ($urandom_range(0, 19) == 0) dwell = 8'($urandom_range(0, 5));
         step();
         for (int k = 0; k < 3; k++) begin
            cmp++;
            if (obs(k) !== expv(k)) begin
               bad++; $display("FAIL random_model dut%0d cycle %0d got %h want %h", k, i, obs(k), expv(k));
            end
         end
         cmp++;
         if ($countones(~y0) !== (v0 ? 1 : 0) || $countones(y1) !== (v1 ? 1 : 0) || $countones(~y2) !== (v2 ? 1 : 0)) begin
            bad++; $display("FAIL random_onehot cycle %0d got y %b %b %b valid %b%b%b", i, y0, y1, y2, v0, v1, v2);
         end
      end
   endtask

   initial begin
      test_reset();
      test_direct();
      test_scan();
      test_dwell_change();
      test_enable();
      test_async_reset();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
      $finish;
   end

endmodule

// File: doc/dec_nx2n_scan.md
Name: dec_nx2n_scan

Overview:
- Parametrised, registered N-to-2^N one-hot decoder with active-low enable and selectable output polarity.
- Successor to the team's 2x4 combinational decoder.
- Adds a scan mode: an internal index steps through every output, holding each one for a programmable dwell time. Used for row/digit strobing in display and keypad multiplexing.
- Sits between the control logic (which supplies sel/mode/dwell) and the pad drivers.

Parameters:
- SEL_W, 2, select width; output width OUT_W = 2**SEL_W is a derived localparam.
- ACTIVE_LOW, 1, 1: active output bit is 0 and inactive bits are 1 (matches the 2x4 decoder); 0: active output bit is 1 and inactive bits are 0.
- DWELL_W, 8, width of the dwell-count input and of the internal dwell counter.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- en_n  in  1  active-low enable; 1 forces all outputs inactive.
- mode  in  1  0 = DIRECT (decode sel), 1 = SCAN (internal index).
- sel  in  SEL_W  select index, used in DIRECT mode only.
- dwell  in  DWELL_W  in SCAN mode each output is held for dwell+1 cycles.
- y  out  OUT_W  decoded output, registered.
- idx  out  SEL_W  index currently driven onto y, registered.
- valid  out  1  1 when exactly one bit of y is active.
- wrap  out  1  one-cycle pulse when the scan index rolls over from OUT_W-1 to 0.

Behaviour:
- Clock, reset and enable: one clock (clk); reset rst_n is asynchronous and active-low. en_n is active-low.
- Reset values (asynchronous, while rst_n=0):
  - y = all inactive (all 1s when ACTIVE_LOW=1, all 0s otherwise).
  - idx=0, valid=0, wrap=0, dwell counter cnt=0, state=IDLE.
- States: IDLE, DIRECT, SCAN. The state and all outputs are registered.
- Next-state priority, evaluated every cycle:
  - en_n=1 -> IDLE.
  - else mode=0 -> DIRECT.
  - else -> SCAN.
- IDLE:
  - y all inactive, valid=0, wrap=0.
  - idx and cnt cleared to 0.
- DIRECT:
  - Latency is 1 cycle: y/idx reflect the sel sampled at the previous rising edge.
  - Bit sel of y is active, all other bits inactive; valid=1.
  - cnt held at 0; wrap=0.
- SCAN, entering from IDLE or DIRECT:
  - First SCAN cycle: idx=0, cnt=0, y=decode(0), valid=1.
  - No wrap pulse on entry.
- SCAN, steady state:
  - If cnt >= dwell: idx <= idx+1 (modulo OUT_W) and cnt <= 0.
  - Otherwise: cnt <= cnt+1.
  - The compare is >= so that lowering dwell mid-scan advances on the next cycle and never stalls.
  - dwell=0 advances idx every cycle.
- wrap:
  - Registered high for exactly the first cycle in which idx=0 after a rollover from OUT_W-1.
  - Low in every other cycle.
- Mode change SCAN->DIRECT: the next cycle shows decode(sel); scan idx/cnt are discarded and restart from 0 on re-entry.
- en_n rising mid-scan: the next cycle goes to IDLE with all outputs inactive. en_n falling with mode=1 restarts the scan at idx=0.
- Output integrity:
  - When valid=1, y always contains exactly one active bit.
  - When valid=0, y has no active bits.
  - y never shows a partial or transitional pattern.
- Width rules:
  - idx arithmetic wraps naturally at SEL_W bits.
  - cnt is unsigned DWELL_W bits and can never overflow, because cnt <= dwell always resets it first.
- rst_n asserted mid-operation: immediate asynchronous return to the reset values. Operation resumes on the first clock edge after release.

Decomposition:
- Shared package dec_pkg:
  - State enum (ST_IDLE, ST_DIRECT, ST_SCAN).
  - Mode constants (MODE_DIRECT=1'b0, MODE_SCAN=1'b1).
  - A function returning the inactive pattern for a given ACTIVE_LOW.
- Sub-module dec_onehot (params SEL_W, ACTIVE_LOW):
  - Purely combinational index-to-one-hot decode, with enable.
  - Instantiated once; its output is registered in dec_nx2n_scan.

Test Plan:
- Reset: SEL_W=2, ACTIVE_LOW=1, hold rst_n=0 -> y=4'b1111, idx=0, valid=0, wrap=0. Assert rst_n asynchronously mid-scan -> the same values appear immediately, without waiting for a clock edge.
- DIRECT: en_n=0, mode=0, sel=0,1,2,3 on consecutive cycles -> one cycle later y=1110,1101,1011,0111 and idx=0..3, valid=1. With ACTIVE_LOW=0 the same stimulus gives 0001,0010,0100,1000.
- SCAN dwell=2: en_n=0, mode=1 -> each idx 0,1,2,3 held 3 cycles; wrap=1 only on the first cycle of idx=0 after idx=3, i.e. the cycle 12 cycles after scan entry.
- Dwell change: scanning with dwell=9 and cnt=6, set dwell=3 -> idx advances on the next cycle. dwell=0 -> idx increments every cycle and wrap fires every 4 cycles.
- Enable/priority: en_n=1 with mode=1 mid-scan -> next cycle y=1111, valid=0. Release en_n -> scan restarts at idx=0 with no wrap pulse.
- Parametrisation: SEL_W=3, dwell=0, scan -> y walks through 8 one-hot codes, wrap every 8 cycles. DIRECT sel=5 -> y=8'b11011111.
